mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the single-port shared data memory (dmem) used by C cores.
- Each cycle it accepts at most one read or write, using rotating priority so no core is starved.
- Read data is returned one cycle after the grant, tagged to the requesting core.
- A bounded bus-hold ("lock") mode lets a core perform atomic read-modify-write sequences.

Parameters:
- C, 8, number of requesting cores (power of two, 2..16).
- IDW, $clog2(C), width of the core index.
- MAX_HOLD, 4, maximum consecutive grants to one core while it holds the bus (1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  C  per-core access request.
- req_we  input  C  per-core 1 = write, 0 = read.
- req_hold  input  C  per-core request to keep the bus after this grant.
- req_adr  input  16×C  per-core address, unpacked array [C-1:0].
- req_wdat  input  16×C  per-core write data, unpacked array [C-1:0].
- gnt  output  C  one-hot grant, combinational in the same cycle as req.
- rvalid  output  C  one-hot; read data for that core is valid this cycle.
- rdat  output  16  read data, shared by all cores (pass-through of mem_rdat).
- mem_adr  output  16  dmem address.
- mem_wdat  output  16  dmem write data.
- mem_we  output  1  dmem write enable.
- mem_rdat  input  16  dmem read data, registered inside dmem (1-cycle latency).

Behaviour:
- State registers: ptr[IDW] (highest-priority index), hold_act, owner[IDW], hold_cnt[4], rvalid[C].
- Reset values: ptr=0, hold_act=0, owner=0, hold_cnt=0, rvalid=0.
- While reset=1: gnt=0 and mem_we=0; mem_adr and mem_wdat are don't-care (drive 0).
- Winner selection, when hold_act=1 and req[owner]=1 and hold_cnt<MAX_HOLD:
  - winner = owner.
- Winner selection otherwise:
  - winner = first i with req[i]=1, scanning ptr, ptr+1, …, C-1, 0, …, ptr-1 (wrap mod C).
- Idle cycle (no req): gnt=0, mem_we=0, no state change except rvalid<=0.
- Grant cycle:
  - gnt[winner]=1.
  - mem_adr=req_adr[winner], mem_wdat=req_wdat[winner], mem_we=req_we[winner].
  - Write commits at that posedge.
- Read response: on a read grant, rvalid<=onehot(winner) at the next posedge; rdat=mem_rdat during that cycle.
  - Back-to-back reads by different cores give back-to-back rvalid pulses.
  - Latency is exactly 1 cycle, with no bubbles.
- ptr update: on every grant, ptr<=(winner+1) mod C, including grants made under hold.
- Hold FSM, state IDLE (hold_act=0):
  - Grant to w with req_hold[w]=1 → ACTIVE, with owner<=w and hold_cnt<=1.
- Hold FSM, state ACTIVE:
  - Grant to owner with req_hold[owner]=1 and hold_cnt<MAX_HOLD → stay, hold_cnt++.
  - req[owner]=0 or req_hold[owner]=0 → IDLE.
  - hold_cnt==MAX_HOLD → IDLE (forced break). That cycle arbitrates by round robin with ptr=owner+1, so the owner is lowest priority.
  - Forced break when no other core requests: owner may win by round robin and re-enters ACTIVE with hold_cnt=1.
- Simultaneous requests are resolved only by rotating priority; read and write have equal priority.
- A requester must keep req and its operands stable until it sees gnt. The arbiter does not latch unaccepted requests.
- Reset asserted mid-operation: a pending rvalid is cleared and not delivered; hold is released.

Decomposition:
- Shared package mem_arb_pkg holds:
  - localparam ADR_W=16 and DAT_W=16.
  - typedef logic [ADR_W-1:0] adr_t.
  - typedef logic [DAT_W-1:0] dat_t.
  - A function onehot(idx) returning C bits.
- One sub-module, rr_pick #(C): combinational rotating-priority encoder with inputs req and ptr, outputs valid and idx.
- The hold FSM and the datapath mux stay in mem_rr_arbiter.

Test Plan:
- Reset then all req=0 → gnt=0, mem_we=0, rvalid=0 for 10 cycles.
- req=8'hFF (all reads) held for 8 cycles after reset → gnt sequence 01,02,04,…,80.
  - rvalid is the same sequence delayed 1 cycle.
  - rdat matches preloaded dmem[adr].
- Core 3 writes adr 0x0010 = 0xBEEF, then core 5 reads 0x0010 next cycle → gnt[5] in cycle 2; rvalid[5]=1 with rdat=0xBEEF in cycle 3.
- Core 2 with req_hold=1, all others requesting, MAX_HOLD=4 → gnt[2] for 4 consecutive cycles, then gnt[3] (ptr=3); core 2 is not re-granted until cores 3..1 are served.
- Core 1 takes hold and drops req_hold after 2 grants while core 6 requests → third cycle gnt[6], hold_act=0.
- Read granted to core 4, reset asserted the next cycle → rvalid stays 0; ptr=0 after reset.

Source files
------------

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and helpers for the dmem round-robin arbiter.
package mem_arb_pkg;
    localparam int ADR_W = 16;
    localparam int DAT_W = 16;
    localparam int C_MAX = 16;

    typedef logic [ADR_W-1:0] adr_t;
    typedef logic [DAT_W-1:0] dat_t;

    // Sized for the widest supported core count; callers keep the low C bits.
    function automatic logic [C_MAX-1:0] onehot(input logic [3:0] idx);
        logic [C_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Core-side request/response bus plus the dmem port of the arbiter.
interface mem_rr_arbiter_if #(parameter int C = 8);
    import mem_arb_pkg::*;

    logic [C-1:0] req;
    logic [C-1:0] req_we;
    logic [C-1:0] req_hold;
    adr_t         req_adr  [C-1:0];
    dat_t         req_wdat [C-1:0];
    logic [C-1:0] gnt;
    logic [C-1:0] rvalid;
    dat_t         rdat;
    adr_t         mem_adr;
    dat_t         mem_wdat;
    logic         mem_we;
    dat_t         mem_rdat;

    modport slave (
        input  req, req_we, req_hold, req_adr, req_wdat, mem_rdat,
        output gnt, rvalid, rdat, mem_adr, mem_wdat, mem_we
    );

    modport master (
        output req, req_we, req_hold, req_adr, req_wdat, mem_rdat,
        input  gnt, rvalid, rdat, mem_adr, mem_wdat, mem_we
    );
endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping mod C.
module rr_pick #(
    parameter int C   = 8,
    parameter int IDW = $clog2(C)
) (
    input  logic [C-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           valid_o,
    output logic [IDW-1:0] idx_o
);
    logic [IDW-1:0] cand;

    // Scan farthest offset first so the nearest requester is the last write.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = C - 1; k >= 0; k--) begin
            cand = ptr_i + IDW'(k);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end
endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin dmem arbiter with bounded bus-hold for atomic RMW sequences.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int C        = 8,
    parameter int IDW      = $clog2(C),
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_rr_arbiter_if.slave   bus
);
    typedef enum logic {HOLD_IDLE, HOLD_ACTIVE} hold_st_e;

    hold_st_e       state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [3:0]     hold_cnt_q, hold_cnt_d;
    logic [C-1:0]   rvalid_q, rvalid_d;

    logic             pick_vld;
    logic [IDW-1:0]   pick_idx;
    logic             hold_sel;
    logic             gnt_vld;
    logic [IDW-1:0]   winner;
    logic [C_MAX-1:0] win_oh;

    rr_pick #(.C(C), .IDW(IDW)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    // ptr already sits at owner+1 during a hold, so a forced break needs no special pointer.
    assign hold_sel = (state_q == HOLD_ACTIVE) && bus.req[owner_q]
                      && (hold_cnt_q < 4'(MAX_HOLD));
    assign gnt_vld  = !reset && (hold_sel || pick_vld);
    assign winner   = hold_sel ? owner_q : pick_idx;
    assign win_oh   = onehot(4'(winner));

    always_comb begin
        bus.gnt      = '0;
        bus.mem_adr  = '0;
        bus.mem_wdat = '0;
        bus.mem_we   = 1'b0;
        if (gnt_vld) begin
            bus.gnt      = win_oh[C-1:0];
            bus.mem_adr  = bus.req_adr[winner];
            bus.mem_wdat = bus.req_wdat[winner];
            bus.mem_we   = bus.req_we[winner];
        end
    end

    assign bus.rvalid = reset ? '0 : rvalid_q;
    assign bus.rdat   = bus.mem_rdat;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        rvalid_d   = '0;
        if (gnt_vld) begin
            ptr_d = winner + IDW'(1);
            if (!bus.req_we[winner]) rvalid_d = win_oh[C-1:0];
        end
        case (state_q)
            HOLD_IDLE: begin
                if (gnt_vld && bus.req_hold[winner]) begin
                    state_d    = HOLD_ACTIVE;
                    owner_d    = winner;
                    hold_cnt_d = 4'd1;
                end
            end
            HOLD_ACTIVE: begin
                if (hold_sel && bus.req_hold[owner_q]) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end else if (gnt_vld && bus.req_hold[winner]) begin
                    owner_d    = winner;
                    hold_cnt_d = 4'd1;
                end else begin
                    state_d    = HOLD_IDLE;
                    hold_cnt_d = '0;
                end
            end
            default: state_d = HOLD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HOLD_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a registered-read dmem model.
module tb_mem_rr_arbiter;
    import mem_arb_pkg::*;

    localparam int C = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_rr_arbiter_if #(.C(C)) bus ();

    mem_rr_arbiter #(.C(C), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dat_t dm [0:255];
    dat_t dm_rdat;
    initial begin
        for (int i = 0; i < 256; i++) dm[i] = 16'(i) ^ 16'hA5A5;
        dm_rdat = '0;
    end
    always @(posedge clk) begin
        if (bus.mem_we) dm[bus.mem_adr[7:0]] <= bus.mem_wdat;
        dm_rdat <= dm[bus.mem_adr[7:0]];
    end
    assign bus.mem_rdat = dm_rdat;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [C-1:0] r, input logic [C-1:0] we, input logic [C-1:0] h);
        bus.req      = r;
        bus.req_we   = we;
        bus.req_hold = h;
    endtask

    task automatic set_adr();
        for (int i = 0; i < C; i++) begin
            bus.req_adr[i]  = 16'h0020 + 16'(i);
            bus.req_wdat[i] = '0;
        end
    endtask

    initial begin
        logic [C-1:0] hseq [12];
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_adr();
        drive('1, '1, '0);
        tick();
        #2;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_we", 32'(bus.mem_we), 32'h0);
        tick();
        drive('0, '0, '0);
        reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            #2;
            chk("idle_gnt", 32'(bus.gnt), 32'h0);
            chk("idle_we", 32'(bus.mem_we), 32'h0);
            chk("idle_rv", 32'(bus.rvalid), 32'h0);
        end

        // all cores reading: grants rotate from core 0
        for (int i = 0; i < C; i++) begin
            tick();
            drive('1, '0, '0);
            #2;
            chk("rr_gnt", 32'(bus.gnt), 32'(1) << i);
            chk("rr_adr", 32'(bus.mem_adr), 32'h20 + 32'(i));
            chk("rr_rv", 32'(bus.rvalid), (i == 0) ? 32'h0 : (32'(1) << (i - 1)));
            if (i > 0) chk("rr_rdat", 32'(bus.rdat), 32'((16'h20 + 16'(i - 1)) ^ 16'hA5A5));
        end
        tick();
        drive('0, '0, '0);
        #2;
        chk("rr_rv_last", 32'(bus.rvalid), 32'h80);
        chk("rr_rdat_last", 32'(bus.rdat), 32'(16'h27 ^ 16'hA5A5));
        chk("rr_gnt_idle", 32'(bus.gnt), 32'h0);

        // write by core 3 then read-back by core 5
        tick();
        bus.req_adr[3]  = 16'h0010;
        bus.req_wdat[3] = 16'hBEEF;
        bus.req_adr[5]  = 16'h0010;
        drive(8'h08, 8'h08, '0);
        #2;
        chk("wr_gnt", 32'(bus.gnt), 32'h08);
        chk("wr_we", 32'(bus.mem_we), 32'h1);
        chk("wr_adr", 32'(bus.mem_adr), 32'h10);
        chk("wr_wdat", 32'(bus.mem_wdat), 32'hBEEF);
        tick();
        drive(8'h20, 8'h00, '0);
        #2;
        chk("rd_gnt", 32'(bus.gnt), 32'h20);
        chk("rd_we", 32'(bus.mem_we), 32'h0);
        chk("wr_no_rv", 32'(bus.rvalid), 32'h0);
        tick();
        drive('0, '0, '0);
        #2;
        chk("rd_rv", 32'(bus.rvalid), 32'h20);
        chk("rd_rdat", 32'(bus.rdat), 32'hBEEF);
        set_adr();

        // ptr=6: core 1 alone moves ptr to 2
        tick();
        drive(8'h02, '0, '0);
        #2;
        chk("pre_hold_gnt", 32'(bus.gnt), 32'h02);

        // core 2 holds for 4, forced break, rotation 3..1, then core 2 again
        hseq = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h08, 8'h10,
                 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
        for (int i = 0; i < 12; i++) begin
            tick();
            drive('1, '0, 8'h04);
            #2;
            chk($sformatf("hold_gnt%0d", i), 32'(bus.gnt), 32'(hseq[i]));
        end
        tick();
        drive('0, '0, '0);
        #2;
        chk("hold_rel_gnt", 32'(bus.gnt), 32'h0);

        // ptr=3: core 7 moves ptr to 0
        tick();
        drive(8'h80, '0, '0);
        #2;
        chk("pre_drop_gnt", 32'(bus.gnt), 32'h80);
        tick();
        drive(8'h42, '0, 8'h02);
        #2;
        chk("drop_gnt0", 32'(bus.gnt), 32'h02);
        tick();
        drive(8'h42, '0, 8'h00);
        #2;
        chk("drop_gnt1", 32'(bus.gnt), 32'h02);
        tick();
        drive(8'h42, '0, 8'h00);
        #2;
        chk("drop_gnt2", 32'(bus.gnt), 32'h40);

        // lone holder: forced break re-enters hold with no gap
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(8'h04, '0, 8'h04);
            #2;
            chk($sformatf("lone_gnt%0d", i), 32'(bus.gnt), 32'h04);
        end
        tick();
        drive('0, '0, '0);
        tick();
        drive(8'h01, '0, '0);
        #2;
        chk("lone_after", 32'(bus.gnt), 32'h01);

        // read to core 4, then reset kills the response
        tick();
        drive(8'h10, '0, '0);
        #2;
        chk("rst_rd_gnt", 32'(bus.gnt), 32'h10);
        tick();
        drive('0, '0, '0);
        reset = 1'b1;
        #2;
        chk("rst_rv_kill", 32'(bus.rvalid), 32'h0);
        chk("rst_mid_gnt", 32'(bus.gnt), 32'h0);
        tick();
        reset = 1'b0;
        #2;
        chk("post_rst_rv", 32'(bus.rvalid), 32'h0);
        tick();
        drive('1, '0, '0);
        #2;
        chk("post_rst_ptr", 32'(bus.gnt), 32'h01);
        chk("post_rst_rv2", 32'(bus.rvalid), 32'h0);
        tick();
        drive('0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
